// File: rtl/alert_rx_multi_pkg.sv
// Shared types for the multi-channel differential alert receiver.
package alert_rx_multi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK_HI = 2'd1,
    PAUSE  = 2'd2
  } chan_state_e;

  // Wide enough for PauseCycles up to 3.
  localparam int unsigned PauseCntW = 2;

  typedef struct packed {
    logic alert;
    logic ping_ok;
    logic ping_fail;
    logic integ_fail;
  } chan_evt_t;

endpackage

// File: rtl/alert_rx_multi_if.sv
// Bundle of alert/ack/ping rails and event outputs between sender side (master)
// and the receiver (slave).
interface alert_rx_multi_if #(
  parameter int NumAlerts = 4,
  parameter int TimeoutW  = 8
);
  // 4-phase handshake per channel: sender raises alert (p=1,n=0); receiver answers
  // with ack (p=1,n=0); sender drops alert; receiver drops ack and pauses before
  // accepting the next alert. Healthy rails are always complementary.
  logic [NumAlerts-1:0]   alert_p_i;
  logic [NumAlerts-1:0]   alert_n_i;
  logic [NumAlerts-1:0]   ack_p_o;
  logic [NumAlerts-1:0]   ack_n_o;
  logic [NumAlerts-1:0]   ping_p_o;
  logic [NumAlerts-1:0]   ping_n_o;
  logic [NumAlerts-1:0]   ping_req_i;
  logic [TimeoutW-1:0]    ping_timeout_i;
  logic [NumAlerts-1:0]   alert_o;
  logic [NumAlerts-1:0]   ping_ok_o;
  logic [NumAlerts-1:0]   ping_fail_o;
  logic [NumAlerts-1:0]   integ_fail_o;
  logic [2*NumAlerts-1:0] dbg_state;

  modport master (
    output alert_p_i, alert_n_i, ping_req_i, ping_timeout_i,
    input  ack_p_o, ack_n_o, ping_p_o, ping_n_o,
    input  alert_o, ping_ok_o, ping_fail_o, integ_fail_o, dbg_state
  );

  modport slave (
    input  alert_p_i, alert_n_i, ping_req_i, ping_timeout_i,
    output ack_p_o, ack_n_o, ping_p_o, ping_n_o,
    output alert_o, ping_ok_o, ping_fail_o, integ_fail_o, dbg_state
  );
endinterface

// File: rtl/alert_rx_chan.sv
// One alert receiver channel: handshake FSM, ping latch/issue and ping timeout.
// ALERT_RX_MULTI_SYNC_EN adds a 2-flop synchroniser on the alert rails.
module alert_rx_chan
  import alert_rx_multi_pkg::*;
#(
  parameter int TimeoutW    = 8,
  parameter int PauseCycles = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alert_p,
  input  logic                alert_n,
  input  logic                ping_req,
  input  logic [TimeoutW-1:0] ping_timeout,
  output logic                ack_p,
  output logic                ack_n,
  output logic                ping_p,
  output logic                ping_n,
  output chan_evt_t           evt,
  output chan_state_e         state
);

  logic in_p, in_n;

`ifdef ALERT_RX_MULTI_SYNC_EN
  logic [1:0] sync_p, sync_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= 2'b00;
      sync_n <= 2'b11;
    end else begin
      sync_p <= {sync_p[0], alert_p};
      sync_n <= {sync_n[0], alert_n};
    end
  end
  assign in_p = sync_p[1];
  assign in_n = sync_n[1];
`else
  assign in_p = alert_p;
  assign in_n = alert_n;
`endif

  logic ap_q, an_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ap_q <= 1'b0;
      an_q <= 1'b1;
    end else begin
      ap_q <= in_p;
      an_q <= in_n;
    end
  end

  logic alert_seen, alert_clear, integ;
  assign alert_seen  = ap_q & ~an_q;
  assign alert_clear = ~ap_q & an_q;
  assign integ       = (ap_q == an_q);

  chan_state_e          state_q, state_d;
  logic [PauseCntW-1:0] pause_cnt_q, pause_cnt_d;
  logic [TimeoutW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic                 latched_q, latched_d;
  logic                 pending_q, pending_d;
  logic                 ping_q, ping_d;
  logic                 ack_p_q, ack_n_q, ping_n_q;
  chan_evt_t            evt_q, evt_d;

  assign cnt_inc = cnt_q + TimeoutW'(1);

  always_comb begin
    state_d     = state_q;
    pause_cnt_d = pause_cnt_q;
    cnt_d       = cnt_q;
    latched_d   = latched_q;
    pending_d   = pending_q;
    ping_d      = ping_q;
    evt_d       = '0;

    // Integrity level every bad cycle, plus one alert pulse on its first cycle.
    evt_d.integ_fail = integ;
    evt_d.alert      = integ & ~evt_q.integ_fail;

    if (ping_req && !pending_q && !latched_q) latched_d = 1'b1;

    if (pending_q) begin
      cnt_d = cnt_inc;
      if ((ping_timeout != '0) && (cnt_inc == ping_timeout)) begin
        pending_d       = 1'b0;
        evt_d.ping_fail = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (alert_seen) begin
          state_d = ACK_HI;
          if (pending_q) begin
            // An answer on the expiry cycle still counts as a ping response.
            evt_d.ping_ok   = 1'b1;
            evt_d.ping_fail = 1'b0;
            pending_d       = 1'b0;
            cnt_d           = '0;
          end else begin
            evt_d.alert = 1'b1;
          end
        end else if (latched_q) begin
          ping_d    = ~ping_q;
          pending_d = 1'b1;
          latched_d = 1'b0;
          cnt_d     = '0;
        end
      end
      ACK_HI: begin
        if (alert_clear) begin
          state_d     = PAUSE;
          pause_cnt_d = '0;
        end
      end
      PAUSE: begin
        if (pause_cnt_q == PauseCntW'(PauseCycles - 1)) state_d = IDLE;
        else pause_cnt_d = pause_cnt_q + PauseCntW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (integ) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pause_cnt_q <= '0;
      cnt_q       <= '0;
      latched_q   <= 1'b0;
      pending_q   <= 1'b0;
      ping_q      <= 1'b0;
      ping_n_q    <= 1'b1;
      ack_p_q     <= 1'b0;
      ack_n_q     <= 1'b1;
      evt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pause_cnt_q <= pause_cnt_d;
      cnt_q       <= cnt_d;
      latched_q   <= latched_d;
      pending_q   <= pending_d;
      ping_q      <= ping_d;
      ping_n_q    <= ~ping_d;
      ack_p_q     <= (state_d == ACK_HI);
      ack_n_q     <= (state_d != ACK_HI);
      evt_q       <= evt_d;
    end
  end

  assign ack_p  = ack_p_q;
  assign ack_n  = ack_n_q;
  assign ping_p = ping_q;
  assign ping_n = ping_n_q;
  assign evt    = evt_q;
  assign state  = state_q;

endmodule

// File: rtl/alert_rx_multi.sv
// N independent differential alert receiver channels behind one interface.
// ALERT_RX_MULTI_SYNC_EN (see alert_rx_chan) adds input synchronisers.
module alert_rx_multi
  import alert_rx_multi_pkg::*;
#(
  parameter int NumAlerts   = 4,
  parameter int TimeoutW    = 8,
  parameter int PauseCycles = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alert_rx_multi_if.slave bus
);

  logic [NumAlerts-1:0]   ack_p, ack_n, ping_p, ping_n;
  logic [NumAlerts-1:0]   ev_alert, ev_ok, ev_fail, ev_integ;
  logic [2*NumAlerts-1:0] dbg;

  for (genvar i = 0; i < NumAlerts; i++) begin : g_chan
    chan_evt_t   evt;
    chan_state_e st;

    alert_rx_chan #(
      .TimeoutW    (TimeoutW),
      .PauseCycles (PauseCycles)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .alert_p      (bus.alert_p_i[i]),
      .alert_n      (bus.alert_n_i[i]),
      .ping_req     (bus.ping_req_i[i]),
      .ping_timeout (bus.ping_timeout_i),
      .ack_p        (ack_p[i]),
      .ack_n        (ack_n[i]),
      .ping_p       (ping_p[i]),
      .ping_n       (ping_n[i]),
      .evt          (evt),
      .state        (st)
    );

    assign ev_alert[i]     = evt.alert;
    assign ev_ok[i]        = evt.ping_ok;
    assign ev_fail[i]      = evt.ping_fail;
    assign ev_integ[i]     = evt.integ_fail;
    assign dbg[2*i +: 2]   = st;
  end

  assign bus.ack_p_o      = ack_p;
  assign bus.ack_n_o      = ack_n;
  assign bus.ping_p_o     = ping_p;
  assign bus.ping_n_o     = ping_n;
  assign bus.alert_o      = ev_alert;
  assign bus.ping_ok_o    = ev_ok;
  assign bus.ping_fail_o  = ev_fail;
  assign bus.integ_fail_o = ev_integ;
  assign bus.dbg_state    = dbg;

endmodule

// File: tb/tb_alert_rx_multi.sv
// Directed scoreboard bench for alert_rx_multi: event and level expectations
// are queued by the stimulus and checked by one negedge monitor.
module tb_alert_rx_multi;

  localparam int N  = 4;
  localparam int TW = 8;

  localparam int K_ALERT = 0;
  localparam int K_OK    = 1;
  localparam int K_FAIL  = 2;
  localparam int K_INTEG = 3;

  localparam int S_ACK_P  = 0;
  localparam int S_ACK_N  = 1;
  localparam int S_PING_P = 2;
  localparam int S_PING_N = 3;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alert_rx_multi_if #(.NumAlerts(N), .TimeoutW(TW)) bus ();

  alert_rx_multi #(.NumAlerts(N), .TimeoutW(TW), .PauseCycles(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // scoreboard queues: {cycle[15:0], kind[7:0], ch[7:0]} and
  // {cycle[15:0], sig[3:0], ch[3:0], 7'b0, value}
  logic [31:0] exp_q[$];
  logic [31:0] lvl_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic done   = 1'b0;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic expect_evt(input int c, input int k, input int ch);
    exp_q.push_back({16'(c), 8'(k), 8'(ch)});
  endtask

  task automatic expect_lvl(input int c, input int sig, input int ch, input logic v);
    lvl_q.push_back({16'(c), 4'(sig), 4'(ch), 7'b0, v});
  endtask

  task automatic drive_alert(input int ch, input logic p, input logic n);
    bus.alert_p_i[ch] = p;
    bus.alert_n_i[ch] = n;
  endtask

  // monitor: the only process that compares and counts
  always @(negedge clk) begin
    logic        hit;
    logic        lv;
    logic [31:0] act;
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      for (int ch = 0; ch < N; ch++) begin
        case (k)
          K_ALERT: hit = bus.alert_o[ch];
          K_OK:    hit = bus.ping_ok_o[ch];
          K_FAIL:  hit = bus.ping_fail_o[ch];
          default: hit = bus.integ_fail_o[ch];
        endcase
        if (hit === 1'b1) begin
          act = {16'(cyc), 8'(k), 8'(ch)};
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got kind %0d ch %0d at cycle %0d, expected no event",
                     k, ch, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
              n_fail++;
              $display("FAIL event: got kind %0d ch %0d cycle %0d, expected kind %0d ch %0d cycle %0d",
                       k, ch, cyc, e[15:8], e[7:0], e[31:16]);
            end
          end
        end
      end
    end

    while (lvl_q.size() > 0 && lvl_q[0][31:16] <= 16'(cyc)) begin
      e = lvl_q.pop_front();
      case (int'(e[15:12]))
        S_ACK_P:  lv = bus.ack_p_o[e[11:8]];
        S_ACK_N:  lv = bus.ack_n_o[e[11:8]];
        S_PING_P: lv = bus.ping_p_o[e[11:8]];
        default:  lv = bus.ping_n_o[e[11:8]];
      endcase
      n_checks++;
      if (e[31:16] != 16'(cyc)) begin
        n_fail++;
        $display("FAIL level sig %0d ch %0d: check for cycle %0d reached at cycle %0d",
                 e[15:12], e[11:8], e[31:16], cyc);
      end else if (lv !== e[0]) begin
        n_fail++;
        $display("FAIL level sig %0d ch %0d cycle %0d: got %b expected %b",
                 e[15:12], e[11:8], cyc, lv, e[0]);
      end
    end

    if (done) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing event: kind %0d ch %0d expected at cycle %0d, never seen",
                 e[15:8], e[7:0], e[31:16]);
      end
      while (lvl_q.size() > 0) begin
        e = lvl_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL level sig %0d ch %0d: check for cycle %0d never reached",
                 e[15:12], e[11:8], e[31:16]);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int t;
    bus.alert_p_i      = '0;
    bus.alert_n_i      = '1;
    bus.ping_req_i     = '0;
    bus.ping_timeout_i = TW'(10);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset values
    step();
    t = cyc;
    for (int ch = 0; ch < N; ch++) begin
      expect_lvl(t, S_ACK_P, ch, 1'b0);
      expect_lvl(t, S_ACK_N, ch, 1'b1);
      expect_lvl(t, S_PING_P, ch, 1'b0);
      expect_lvl(t, S_PING_N, ch, 1'b1);
    end

    // ch0: alert handshake, pause enforcement, ping deferred past handshake
    step();
    t = cyc;
    drive_alert(0, 1'b1, 1'b0);
    expect_evt(t + 2, K_ALERT, 0);
    goto(t + 2);
    expect_lvl(t + 2, S_ACK_P, 0, 1'b1);
    expect_lvl(t + 2, S_ACK_N, 0, 1'b0);
    goto(t + 5);
    drive_alert(0, 1'b0, 1'b1);
    goto(t + 6);
    expect_lvl(t + 6, S_ACK_P, 0, 1'b1);
    goto(t + 7);
    expect_lvl(t + 7, S_ACK_P, 0, 1'b0);
    expect_lvl(t + 7, S_ACK_N, 0, 1'b1);
    drive_alert(0, 1'b1, 1'b0);
    expect_evt(t + 10, K_ALERT, 0);
    goto(t + 9);
    expect_lvl(t + 9, S_ACK_P, 0, 1'b0);
    goto(t + 10);
    expect_lvl(t + 10, S_ACK_P, 0, 1'b1);
    goto(t + 11);
    bus.ping_req_i[0] = 1'b1;
    goto(t + 12);
    bus.ping_req_i[0] = 1'b0;
    drive_alert(0, 1'b0, 1'b1);
    goto(t + 16);
    expect_lvl(t + 16, S_PING_P, 0, 1'b0);
    goto(t + 17);
    expect_lvl(t + 17, S_PING_P, 0, 1'b1);
    expect_lvl(t + 17, S_PING_N, 0, 1'b0);
    expect_evt(t + 27, K_FAIL, 0);
    goto(t + 18);
    bus.ping_req_i[0] = 1'b1;
    goto(t + 19);
    bus.ping_req_i[0] = 1'b0;
    goto(t + 32);
    expect_lvl(t + 32, S_PING_P, 0, 1'b1);

    // ch1: ping answered after 4 cycles
    goto(t + 34);
    t = cyc;
    bus.ping_req_i[1] = 1'b1;
    goto(t + 1);
    bus.ping_req_i[1] = 1'b0;
    goto(t + 2);
    expect_lvl(t + 2, S_PING_P, 1, 1'b1);
    expect_lvl(t + 2, S_PING_N, 1, 1'b0);
    goto(t + 6);
    drive_alert(1, 1'b1, 1'b0);
    expect_evt(t + 8, K_OK, 1);
    goto(t + 8);
    expect_lvl(t + 8, S_ACK_P, 1, 1'b1);
    goto(t + 9);
    drive_alert(1, 1'b0, 1'b1);

    // ch2: ping timeout, then timeout disabled and answered late
    goto(t + 20);
    t = cyc;
    bus.ping_req_i[2] = 1'b1;
    goto(t + 1);
    bus.ping_req_i[2] = 1'b0;
    expect_evt(t + 12, K_FAIL, 2);
    goto(t + 2);
    expect_lvl(t + 2, S_PING_P, 2, 1'b1);
    goto(t + 14);
    bus.ping_timeout_i = '0;
    bus.ping_req_i[2]  = 1'b1;
    goto(t + 15);
    bus.ping_req_i[2] = 1'b0;
    goto(t + 16);
    expect_lvl(t + 16, S_PING_P, 2, 1'b0);
    expect_lvl(t + 16, S_PING_N, 2, 1'b1);
    goto(t + 60);
    expect_lvl(t + 60, S_PING_P, 2, 1'b0);
    drive_alert(2, 1'b1, 1'b0);
    expect_evt(t + 62, K_OK, 2);
    goto(t + 64);
    drive_alert(2, 1'b0, 1'b1);
    goto(t + 66);
    bus.ping_timeout_i = TW'(10);

    // ch3: integrity failure for 3 cycles
    goto(t + 70);
    t = cyc;
    drive_alert(3, 1'b1, 1'b1);
    expect_evt(t + 2, K_ALERT, 3);
    expect_evt(t + 2, K_INTEG, 3);
    expect_evt(t + 3, K_INTEG, 3);
    expect_evt(t + 4, K_INTEG, 3);
    goto(t + 3);
    expect_lvl(t + 3, S_ACK_P, 3, 1'b0);
    expect_lvl(t + 3, S_ACK_N, 3, 1'b1);
    drive_alert(3, 1'b0, 1'b1);

    // ch1: reset asserted while ack is high
    goto(t + 10);
    t = cyc;
    drive_alert(1, 1'b1, 1'b0);
    expect_evt(t + 2, K_ALERT, 1);
    goto(t + 2);
    expect_lvl(t + 2, S_ACK_P, 1, 1'b1);
    goto(t + 3);
    rst_n = 1'b0;
    drive_alert(1, 1'b0, 1'b1);
    expect_lvl(t + 3, S_ACK_P, 1, 1'b0);
    expect_lvl(t + 3, S_ACK_N, 1, 1'b1);
    expect_lvl(t + 3, S_PING_P, 0, 1'b0);
    expect_lvl(t + 3, S_PING_P, 1, 1'b0);
    goto(t + 5);
    rst_n = 1'b1;
    goto(t + 8);
    expect_lvl(t + 8, S_ACK_P, 1, 1'b0);
    expect_lvl(t + 8, S_PING_N, 0, 1'b1);

    goto(t + 20);
    done = 1'b1;
  end

endmodule

// File: doc/alert_rx_multi.md
Name: alert_rx_multi

Overview:
Parametrised N-channel differential alert receiver for the alert handler front end. Per channel it performs the full 4-phase alert/ack handshake, issues differential ping requests, and times out missing ping responses. It checks differential encoding integrity and reports alert, ping-ok, ping-fail and integrity-fail events as single-cycle pulses. It pairs with the existing alert sender and its DV agent, and generalises a single fixed pair to NumAlerts independent channels.

Parameters:
NumAlerts, 4, number of independent alert channels (1..32)
TimeoutW, 8, width of ping timeout counter and timeout input
PauseCycles, 2, idle cycles enforced after ack deassertion before next handshake (1..3)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
alert_p_i  input  NumAlerts  differential alert, positive rail
alert_n_i  input  NumAlerts  differential alert, negative rail
ack_p_o  output  NumAlerts  ack, positive rail
ack_n_o  output  NumAlerts  ack, negative rail
ping_p_o  output  NumAlerts  ping, positive rail (level toggles per request)
ping_n_o  output  NumAlerts  ping, negative rail
ping_req_i  input  NumAlerts  one-cycle ping request pulse per channel
ping_timeout_i  input  TimeoutW  ping timeout in cycles; 0 disables timeout
alert_o  output  NumAlerts  pulse: genuine alert received
ping_ok_o  output  NumAlerts  pulse: ping answered
ping_fail_o  output  NumAlerts  pulse: ping timed out
integ_fail_o  output  NumAlerts  level: alert_p_i == alert_n_i (registered)

Behaviour:
- Reset: ack_p_o=0, ack_n_o=1, ping_p_o=0, ping_n_o=1, all event outputs 0, FSM Idle, ping pending cleared, counters 0.
- Inputs registered once (reg stage); all decisions use registered values; all outputs registered.
- Per-channel FSM: Idle -> AckHi on registered alert (p=1,n=0); AckHi -> Pause when registered alert returns (p=0,n=1); Pause holds PauseCycles cycles with ack low -> Idle.
- Entering AckHi: ack_p_o=1/ack_n_o=0 one cycle after registered alert; leaving AckHi: ack back to 0/1 on the same edge.
- Latency: alert_i rising at edge t -> alert_o (or ping_ok_o) pulse and ack_p_o high after edge t+2.
- Alert classification on Idle->AckHi: if ping pending -> ping_ok_o pulse, pending cleared, counter cleared; else alert_o pulse. Exactly one of the two per handshake.
- Ping: ping_req_i accepted in any state; if no ping pending, latch request. A latched request is issued in Idle only: toggle ping_p_o, ping_n_o=~ping_p_o, set pending, load counter. A ping_req_i while a ping is pending is dropped (no double-count).
- Timeout: counter increments while pending; when counter == ping_timeout_i (nonzero) -> ping_fail_o pulse, pending cleared. An answer arriving on the same cycle as expiry counts as ping_ok (answer wins).
- Integrity: registered p==n -> integ_fail_o high every such cycle; FSM forced to Idle, ack driven 0/1, pending ping unaffected. The first cycle of an integrity failure also pulses alert_o.
- Simultaneous alert and ping issue in Idle: handshake takes priority; ping issue deferred until next Idle.
- Reset mid-handshake: async return to reset values; no event pulses emitted.
- Channels fully independent; no cross-channel arbitration.

Optional Feature:
ALERT_RX_MULTI_SYNC_EN: when defined, alert_p_i/alert_n_i pass through a 2-flop synchroniser before the input register; all alert-path latencies grow by 2 cycles (alert->ack = t+4). When undefined, inputs are synchronous to clk and latencies are as above.

Decomposition:
- Package alert_rx_multi_pkg: channel FSM state enum (Idle, AckHi, Pause), pause-counter width constant, event struct {alert, ping_ok, ping_fail, integ_fail}.
- Sub-module alert_rx_chan: one channel (FSM, ping latch, timeout counter). The top level instantiates NumAlerts copies and concatenates their outputs.

Test Plan:
- Ch0 alert_p/n 1/0 for 5 cycles then 0/1 -> alert_o[0] single pulse at t+2, ack_p_o[0] high until 1 cycle after registered deassert, next handshake accepted only after 2 pause cycles.
- ping_req_i[1], ping_timeout_i=10, sender answers after 4 cycles -> ping_p_o[1] toggles 0->1, ping_ok_o[1] pulse, no alert_o[1].
- ping_req_i[2], timeout=10, no answer -> ping_fail_o[2] pulse exactly 10 cycles after issue; timeout=0 -> never fails.
- alert_p=alert_n=1 on ch3 for 3 cycles -> integ_fail_o[3] high 3 cycles, one alert_o[3] pulse, ack 0/1.
- ping_req_i[0] during active handshake -> ping issued in first Idle cycle after pause; second req while pending -> ignored.
- rst_n low during AckHi -> ack_p_o=0, ack_n_o=1 immediately, no pulses after release.
